// File: rtl/gcd_pkg.sv
// Shared types and helpers for the GCD requester front end.
package gcd_pkg;

    localparam int OPW   = 16;
    localparam int DATAW = 2 * OPW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } gcd_state_t;

    // Core input word layout: operand B in the upper half, A in the lower half.
    function automatic logic [DATAW-1:0] pack(input logic [OPW-1:0] a, input logic [OPW-1:0] b);
        return {b, a};
    endfunction

endpackage

// File: rtl/gcd_rsp_fifo.sv
// In-order response FIFO; head data reads as zero while empty so the
// output port has a defined value out of reset.
module gcd_rsp_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign empty    = (cnt == '0);
    assign full     = (cnt == CW'(DEPTH));
    assign count    = cnt;
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; emptiness is tracked by the counters alone.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/gcd_client.sv
// Requester-side front end for the GCD core: zero-operand shortcut,
// single outstanding request, WAIT timeout and buffered responses.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int RSP_DEPTH = 4,
    parameter int TIMEOUT   = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [OPW-1:0]             req_a,
    input  logic [OPW-1:0]             req_b,
    output logic                       gcd_in_valid,
    input  logic                       gcd_in_ready,
    output logic [DATAW-1:0]           gcd_in_data,
    input  logic                       gcd_out_valid,
    input  logic [OPW-1:0]             gcd_out_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [OPW-1:0]             rsp_data,
    output logic                       timeout_err,
    output gcd_state_t                 fsm_state,
    output logic [$clog2(RSP_DEPTH):0] rsp_count
);

    localparam int TW = $clog2(TIMEOUT);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high; req and rsp obey this, gcd_out_valid is a one-cycle
    // pulse that cannot be stalled and is only honoured in WAIT.

    gcd_state_t       state;
    gcd_state_t       next_state;
    logic [DATAW-1:0] op_data;
    logic [TW-1:0]    timer;
    logic             accept;
    logic             zero_op;
    logic             load_op;
    logic             timer_clr;
    logic             set_err;
    logic             push;
    logic [OPW-1:0]   push_data;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;

    assign req_ready    = reset & (state == IDLE) & ~fifo_full;
    assign accept       = req_valid & req_ready;
    assign zero_op      = (req_a == '0) | (req_b == '0);
    assign gcd_in_valid = (state == ISSUE);
    assign gcd_in_data  = op_data;
    assign rsp_valid    = ~fifo_empty;
    assign pop          = rsp_valid & rsp_ready;
    assign fsm_state    = state;

    always_comb begin
        next_state = state;
        load_op    = 1'b0;
        timer_clr  = 1'b0;
        set_err    = 1'b0;
        push       = 1'b0;
        push_data  = gcd_out_data;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (zero_op) begin
                        // The core hangs on a zero operand, so answer locally.
                        push      = 1'b1;
                        push_data = req_a | req_b;
                    end else begin
                        load_op    = 1'b1;
                        next_state = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (gcd_in_ready) begin
                    timer_clr  = 1'b1;
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (gcd_out_valid) begin
                    push       = 1'b1;
                    next_state = IDLE;
                end else if (timer == TW'(TIMEOUT - 1)) begin
                    set_err    = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            op_data     <= '0;
            timer       <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= next_state;
            if (load_op) op_data <= pack(req_a, req_b);
            if (timer_clr) timer <= '0;
            else if (state == WAIT) timer <= timer + 1'b1;
            if (set_err) timeout_err <= 1'b1;
        end
    end

    gcd_rsp_fifo #(
        .W     (OPW),
        .DEPTH (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (rsp_data),
        .count     (rsp_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client with a hand-driven GCD core stub.
module tb_gcd_client;
    import gcd_pkg::*;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_a;
    logic [15:0] req_b;
    logic        gcd_in_valid;
    logic        gcd_in_ready;
    logic [31:0] gcd_in_data;
    logic        gcd_out_valid;
    logic [15:0] gcd_out_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        timeout_err;
    gcd_state_t  fsm_state;
    logic [2:0]  rsp_count;

    int total = 0;
    int bad   = 0;
    int in_valid_cnt = 0;
    int base_cnt;
    logic [15:0] exp_q[$];

    gcd_client #(
        .RSP_DEPTH (4),
        .TIMEOUT   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .gcd_in_valid  (gcd_in_valid),
        .gcd_in_ready  (gcd_in_ready),
        .gcd_in_data   (gcd_in_data),
        .gcd_out_valid (gcd_out_valid),
        .gcd_out_data  (gcd_out_data),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data),
        .timeout_err   (timeout_err),
        .fsm_state     (fsm_state),
        .rsp_count     (rsp_count)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    always @(posedge clk) begin
        if (gcd_in_valid) in_valid_cnt <= in_valid_cnt + 1;
    end

    function automatic logic [15:0] gcd_model(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] t;
        x = a;
        y = b;
        while (y != 16'd0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        total++;
        assert (obs === want) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, want);
        end
    endtask

    // Driver: offer a pair and return at the negedge after acceptance.
    task automatic send_req(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_a = a;
        req_b = b;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Core stub: take the input handshake, then pulse one result.
    task automatic core_serve(input logic [15:0] a, input logic [15:0] b);
        gcd_in_ready = 1'b1;
        @(negedge clk);
        gcd_in_ready = 1'b0;
        repeat (2) @(negedge clk);
        gcd_out_valid = 1'b1;
        gcd_out_data  = gcd_model(a, b);
        @(negedge clk);
        gcd_out_valid = 1'b0;
    endtask

    // Scoreboard: compare head of FIFO against the expected queue, then pop.
    task automatic pop_expect(input string tag);
        logic [15:0] want;
        want = exp_q.pop_front();
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk(tag, {16'd0, rsp_data}, {16'd0, want});
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = 1'b0;
        req_a = '0;
        req_b = '0;
        gcd_in_ready = 1'b0;
        gcd_out_valid = 1'b0;
        gcd_out_data = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_in_valid", {31'd0, gcd_in_valid}, 32'd0);
        chk("rst_in_data", gcd_in_data, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("post_rst_state", 32'(fsm_state), 32'(IDLE));

        // Basic issue: gcd(12,18)
        send_req(16'd12, 16'd18);
        chk("basic_in_valid", {31'd0, gcd_in_valid}, 32'd1);
        chk("basic_in_data", gcd_in_data, 32'h0012000C);
        chk("basic_state", 32'(fsm_state), 32'(ISSUE));
        core_serve(16'd12, 16'd18);
        chk("basic_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("basic_rsp_data", {16'd0, rsp_data}, 32'd6);
        chk("basic_ready_back", {31'd0, req_ready}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("basic_drained", {31'd0, rsp_valid}, 32'd0);

        // Zero shortcut: (0,35) then (0,0)
        base_cnt = in_valid_cnt;
        send_req(16'd0, 16'd35);
        chk("zero_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        chk("zero_rsp_35", {16'd0, rsp_data}, 32'd35);
        chk("zero_state", 32'(fsm_state), 32'(IDLE));
        send_req(16'd0, 16'd0);
        exp_q.push_back(16'd35);
        exp_q.push_back(16'd0);
        pop_expect("zero_first");
        pop_expect("zero_second");
        chk("zero_empty", {31'd0, rsp_valid}, 32'd0);
        chk("zero_no_issue", 32'(in_valid_cnt - base_cnt), 32'd0);

        // Backpressure: fill all four entries with rsp_ready low
        send_req(16'd48, 16'd18);
        core_serve(16'd48, 16'd18);
        send_req(16'd7, 16'd5);
        core_serve(16'd7, 16'd5);
        send_req(16'd100, 16'd75);
        core_serve(16'd100, 16'd75);
        send_req(16'd9, 16'd9);
        core_serve(16'd9, 16'd9);
        chk("bp_ready_low", {31'd0, req_ready}, 32'd0);
        chk("bp_count", {29'd0, rsp_count}, 32'd4);
        exp_q.push_back(16'd6);
        exp_q.push_back(16'd1);
        exp_q.push_back(16'd25);
        exp_q.push_back(16'd9);
        for (int i = 0; i < 4; i++) pop_expect("bp_drain");
        chk("bp_empty", {31'd0, rsp_valid}, 32'd0);
        chk("bp_ready_back", {31'd0, req_ready}, 32'd1);

        // Core stall: gcd_in_ready low for 10 cycles
        send_req(16'd21, 16'd14);
        for (int i = 0; i < 10; i++) begin
            chk("stall_valid", {31'd0, gcd_in_valid}, 32'd1);
            chk("stall_data", gcd_in_data, 32'h000E0015);
            chk("stall_state", 32'(fsm_state), 32'(ISSUE));
            @(negedge clk);
        end
        core_serve(16'd21, 16'd14);
        exp_q.push_back(16'd7);
        pop_expect("stall_rsp");

        // Timeout: core never answers
        send_req(16'd8, 16'd4);
        gcd_in_ready = 1'b1;
        @(negedge clk);
        gcd_in_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
        chk("to_still_wait", 32'(fsm_state), 32'(WAIT));
        @(negedge clk);
        chk("to_err", {31'd0, timeout_err}, 32'd1);
        chk("to_idle", 32'(fsm_state), 32'(IDLE));
        chk("to_ready", {31'd0, req_ready}, 32'd1);
        chk("to_no_rsp", {31'd0, rsp_valid}, 32'd0);
        gcd_out_valid = 1'b1;
        gcd_out_data  = 16'd4;
        @(negedge clk);
        gcd_out_valid = 1'b0;
        @(negedge clk);
        chk("late_dropped", {31'd0, rsp_valid}, 32'd0);
        chk("late_count", {29'd0, rsp_count}, 32'd0);
        chk("to_sticky", {31'd0, timeout_err}, 32'd1);

        // Reset mid-WAIT with two buffered entries
        send_req(16'd0, 16'd5);
        send_req(16'd3, 16'd0);
        send_req(16'd6, 16'd4);
        gcd_in_ready = 1'b1;
        @(negedge clk);
        gcd_in_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_wait_state", 32'(fsm_state), 32'(WAIT));
        chk("mid_wait_count", {29'd0, rsp_count}, 32'd2);
        reset = 1'b0;
        #1;
        chk("mrst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("mrst_in_valid", {31'd0, gcd_in_valid}, 32'd0);
        chk("mrst_in_data", gcd_in_data, 32'd0);
        chk("mrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mrst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("mrst_timeout", {31'd0, timeout_err}, 32'd0);
        chk("mrst_state", 32'(fsm_state), 32'(IDLE));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_mrst_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        chk("post_mrst_ready", {31'd0, req_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
